// File: rtl/cdc_pkg.sv
// ---------------------------------------------------------------------------
// cdc_pkg
//   Shared definitions for the cdc_handshake_tx source-side 4-phase crossing:
//   FSM state encoding and default parameter values.
// ---------------------------------------------------------------------------
package cdc_pkg;

    // 2-bit state encoding, fixed so external debug taps stay meaningful.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_REQ   = 2'd2,
        ST_REL   = 2'd3
    } cdc_state_e;

    localparam int unsigned CDC_WIDTH_DEFAULT       = 8;
    localparam int unsigned CDC_SYNC_STAGES_DEFAULT = 2;
    localparam int unsigned CDC_TIMEOUT_DEFAULT     = 1023;

endpackage : cdc_pkg

// File: rtl/sync_chain.sv
// ---------------------------------------------------------------------------
// sync_chain
//   N-flop single-bit synchronizer for an asynchronous input. All flops reset
//   to 0, so the output reads 0 until the input has travelled the full chain.
//
// Ports
//   clock    in  1  destination clock
//   reset_n  in  1  asynchronous active-low reset
//   d_i      in  1  asynchronous input bit
//   q_o      out 1  synchronized bit (SYNC_STAGES cycles latency, +1 uncertainty)
// ---------------------------------------------------------------------------
module sync_chain
    import cdc_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = CDC_SYNC_STAGES_DEFAULT
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule : sync_chain

// File: rtl/cdc_handshake_tx.sv
// ---------------------------------------------------------------------------
// cdc_handshake_tx
//   Source end of a 4-phase req/ack clock-domain crossing. A word accepted on
//   in_valid/in_ready is registered onto tx_data, then tx_req is raised one
//   cycle later. The transfer completes once the synchronized tx_ack has risen
//   and fallen again, at which point done pulses for one cycle.
//
//   Optional feature macro: CDC_TX_TIMEOUT_EN
//     defined   : REQ gives up after TIMEOUT_CYCLES cycles without ack,
//                 drops tx_req, pulses err, then still waits for ack low.
//     undefined : REQ waits indefinitely, err is tied 0.
//
// Ports
//   clock     in  1      single clock, all state on posedge
//   reset_n   in  1      asynchronous active-low reset
//   in_valid  in  1      local word offered
//   in_data   in  WIDTH  local word, taken when in_valid && in_ready
//   in_ready  out 1      block can accept a word this cycle
//   tx_req    out 1      registered request to the remote domain
//   tx_data   out WIDTH  registered word, stable from before tx_req until ack falls
//   tx_ack    in  1      asynchronous acknowledge from the remote domain
//   done      out 1      one-cycle pulse when a handshake fully completes
//   err       out 1      one-cycle pulse on request timeout (feature builds only)
// ---------------------------------------------------------------------------
module cdc_handshake_tx
    import cdc_pkg::*;
#(
    parameter int unsigned WIDTH          = CDC_WIDTH_DEFAULT,
    parameter int unsigned SYNC_STAGES    = CDC_SYNC_STAGES_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = CDC_TIMEOUT_DEFAULT
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             tx_req,
    output logic [WIDTH-1:0] tx_data,
    input  logic             tx_ack,
    output logic             done,
    output logic             err
);

    if (WIDTH < 1 || SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("cdc_handshake_tx: WIDTH>=1, SYNC_STAGES>=2, TIMEOUT_CYCLES>=1 required");
    end

    logic ack_s;

    sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_ack_sync (
        .clock  (clock),
        .reset_n(reset_n),
        .d_i    (tx_ack),
        .q_o    (ack_s)
    );

    cdc_state_e             state_q, state_d;
    logic [WIDTH-1:0]       data_q,  data_d;
    logic                   req_q,   req_d;
    logic                   done_q,  done_d;
    // Fills with ones over the first SYNC_STAGES cycles after reset. Until it is
    // full, ack_s still reflects the reset value of the synchronizer rather than
    // the real tx_ack, so a stale high ack would otherwise be missed.
    logic [SYNC_STAGES-1:0] prime_q;
    logic                   accept_ok;

`ifdef CDC_TX_TIMEOUT_EN
    localparam int unsigned  CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             abort_q, abort_d;
    logic             err_q,   err_d;
`endif

    assign accept_ok = (state_q == ST_IDLE) && prime_q[SYNC_STAGES-1] && !ack_s;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        req_d   = req_q;
        done_d  = 1'b0;
`ifdef CDC_TX_TIMEOUT_EN
        cnt_d   = cnt_q;
        abort_d = abort_q;
        err_d   = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid && accept_ok) begin
                    data_d  = in_data;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                // ack_s is deliberately not looked at here; REQ re-checks it.
                req_d   = 1'b1;
                state_d = ST_REQ;
`ifdef CDC_TX_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_REQ: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = ST_REL;
                end
`ifdef CDC_TX_TIMEOUT_EN
                else begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (cnt_d == CNT_MAX) begin
                        req_d   = 1'b0;
                        err_d   = 1'b1;
                        abort_d = 1'b1;
                        state_d = ST_REL;
                    end
                end
`endif
            end
            ST_REL: begin
                if (!ack_s) begin
                    state_d = ST_IDLE;
`ifdef CDC_TX_TIMEOUT_EN
                    // An aborted word ends silently: err already reported it.
                    done_d  = !abort_q;
                    abort_d = 1'b0;
`else
                    done_d  = 1'b1;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            prime_q <= '0;
`ifdef CDC_TX_TIMEOUT_EN
            cnt_q   <= '0;
            abort_q <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            req_q   <= req_d;
            done_q  <= done_d;
            prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
`ifdef CDC_TX_TIMEOUT_EN
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
            err_q   <= err_d;
`endif
        end
    end

    assign in_ready = accept_ok;
    assign tx_req   = req_q;
    assign tx_data  = data_q;
    assign done     = done_q;
`ifdef CDC_TX_TIMEOUT_EN
    assign err      = err_q;
`else
    assign err      = 1'b0;
`endif

endmodule : cdc_handshake_tx
